// File: rtl/acsi_sector_sequencer.sv
// Splits an ACSI multi-sector request into single-sector SD controller requests,
// pacing each sector against the DMA engine and returning the ACSI handshakes.
module acsi_sector_sequencer #(
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  data_rd_req,
  input  logic [1:0]  data_wr_req,
  input  logic [31:0] data_lba,
  input  logic [15:0] data_length,
  output logic        data_busy,
  output logic        data_done,
  output logic        data_next,
  output logic        dma_done,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic        dma_sector_ack,
  output logic        xfer_err,
  output logic [15:0] remaining
);

  typedef enum logic [2:0] {StIdle, StWaitBusy, StWaitDone, StWaitDma, StWaitReq} state_e;

  state_e      r_state;
  logic        r_tgt;
  logic        r_wr;
  logic        r_ack_pend;
  logic [23:0] r_cnt;

  logic       w_any_req;
  logic       w_sel_tgt;
  logic       w_sel_wr;
  logic       w_same_req;
  logic       w_to_hit;
  logic       w_ack;
  logic [1:0] w_sel_oh;
  logic [1:0] w_cur_oh;

  // Fixed priority: rd[0], wr[0], rd[1], wr[1].
  always_comb begin
    w_sel_tgt = 1'b0;
    w_sel_wr  = 1'b0;
    if (!data_rd_req[0]) begin
      if (data_wr_req[0]) begin
        w_sel_wr = 1'b1;
      end else if (data_rd_req[1]) begin
        w_sel_tgt = 1'b1;
      end else if (data_wr_req[1]) begin
        w_sel_tgt = 1'b1;
        w_sel_wr  = 1'b1;
      end
    end
  end

  assign w_any_req  = |{data_rd_req, data_wr_req};
  assign w_sel_oh   = w_sel_tgt ? 2'b10 : 2'b01;
  assign w_cur_oh   = r_tgt ? 2'b10 : 2'b01;
  assign w_same_req = r_wr ? data_wr_req[r_tgt] : data_rd_req[r_tgt];
  assign w_to_hit   = (TIMEOUT != 24'd0) && (r_cnt == TIMEOUT - 24'd1);
  assign w_ack      = dma_sector_ack || r_ack_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_tgt      <= 1'b0;
      r_wr       <= 1'b0;
      r_ack_pend <= 1'b0;
      r_cnt      <= '0;
      data_busy  <= 1'b0;
      data_done  <= 1'b0;
      data_next  <= 1'b0;
      dma_done   <= 1'b0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      sd_lba     <= '0;
      xfer_err   <= 1'b0;
      remaining  <= '0;
    end else begin
      data_busy <= 1'b0;
      data_done <= 1'b0;
      data_next <= 1'b0;
      dma_done  <= 1'b0;
      r_cnt     <= '0;
      case (r_state)
        StIdle: begin
          r_ack_pend <= 1'b0;
          // ACSI still holds the request during the cycle data_busy is visible.
          if (w_any_req && !data_busy) begin
            r_tgt     <= w_sel_tgt;
            r_wr      <= w_sel_wr;
            remaining <= data_length;
            sd_lba    <= data_lba;
            xfer_err  <= 1'b0;
            if (data_length == 16'd0) begin
              data_busy <= 1'b1;
              dma_done  <= 1'b1;
            end else begin
              sd_rd   <= w_sel_wr ? 2'b00 : w_sel_oh;
              sd_wr   <= w_sel_wr ? w_sel_oh : 2'b00;
              r_state <= StWaitBusy;
            end
          end
        end
        StWaitBusy: begin
          if (sd_busy) begin
            sd_rd     <= '0;
            sd_wr     <= '0;
            data_busy <= 1'b1;
            if (sd_done) begin
              data_done <= 1'b1;
              r_state   <= StWaitDma;
            end else begin
              r_state <= StWaitDone;
            end
          end else if (w_to_hit) begin
            sd_rd     <= '0;
            sd_wr     <= '0;
            data_busy <= 1'b1;
            dma_done  <= 1'b1;
            xfer_err  <= 1'b1;
            remaining <= '0;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        StWaitDone: begin
          if (dma_sector_ack) r_ack_pend <= 1'b1;
          if (sd_done) begin
            data_done <= 1'b1;
            r_state   <= StWaitDma;
          end else if (w_to_hit) begin
            dma_done  <= 1'b1;
            xfer_err  <= 1'b1;
            remaining <= '0;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        StWaitDma: begin
          if (w_ack) begin
            r_ack_pend <= 1'b0;
            if (remaining <= 16'd1) begin
              remaining <= '0;
              dma_done  <= 1'b1;
              r_state   <= StIdle;
            end else begin
              remaining <= remaining - 16'd1;
              data_next <= 1'b1;
              r_state   <= StWaitReq;
            end
          end else if (w_to_hit) begin
            dma_done  <= 1'b1;
            xfer_err  <= 1'b1;
            remaining <= '0;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        StWaitReq: begin
          if (w_same_req) begin
            sd_lba  <= data_lba;
            sd_rd   <= r_wr ? 2'b00 : w_cur_oh;
            sd_wr   <= r_wr ? w_cur_oh : 2'b00;
            r_state <= StWaitBusy;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acsi_sector_sequencer.sv
// Self-checking bench: ACSI, SD controller and DMA are modelled behaviourally around the DUT.
module tb_acsi_sector_sequencer;

  localparam logic [23:0] Tmo = 24'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  data_rd_req, data_wr_req;
  logic [31:0] data_lba;
  logic [15:0] data_length;
  logic        data_busy, data_done, data_next, dma_done;
  logic [1:0]  sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_busy, sd_done, dma_sector_ack;
  logic        xfer_err;
  logic [15:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acsi_sector_sequencer #(.TIMEOUT(Tmo)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_rd_req    (data_rd_req),
    .data_wr_req    (data_wr_req),
    .data_lba       (data_lba),
    .data_length    (data_length),
    .data_busy      (data_busy),
    .data_done      (data_done),
    .data_next      (data_next),
    .dma_done       (dma_done),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_lba         (sd_lba),
    .sd_busy        (sd_busy),
    .sd_done        (sd_done),
    .dma_sector_ack (dma_sector_ack),
    .xfer_err       (xfer_err),
    .remaining      (remaining)
  );

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] lba;
    logic [15:0] len;
    int          busy_dly;
    int          done_dly;
    int          ack_dly;
    int          req_dly;
    bit          early;
    bit          never_busy;
    bit          noise;
    bit          exp_tgt;
    bit          exp_wr;
    int          exp_busy;
    int          exp_done;
    int          exp_next;
    int          exp_sd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: lowest index in (rd0, wr0, rd1, wr1) wins.
  function automatic void ref_select(input logic [1:0] rd, input logic [1:0] wr,
                                     output bit tgt, output bit is_wr);
    logic [3:0] order;
    order = {wr[1], rd[1], wr[0], rd[0]};
    tgt   = 1'b0;
    is_wr = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (order[i]) begin
        tgt   = (i >= 2);
        is_wr = (i % 2) == 1;
      end
    end
  endfunction

  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    bit   t, w;
    r = v;
    ref_select(v.rd, v.wr, t, w);
    r.exp_tgt  = t;
    r.exp_wr   = w;
    r.exp_busy = (v.len == 16'd0) ? 1 : int'(v.len);
    r.exp_done = int'(v.len);
    r.exp_next = (v.len == 16'd0) ? 0 : int'(v.len) - 1;
    r.exp_sd   = int'(v.len);
    r.exp_err  = 1'b0;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input string nm);
    int          c_busy = 0, c_done = 0, c_next = 0, c_dma = 0, c_sd = 0;
    int          phase = 0, busy_cnt = 0, done_cnt = 0, ack_cnt = 0, req_cnt = 0;
    int          cyc, det_cyc = 0, done_cyc = 0, settle = 0;
    bit          early_ack = 1'b0, finished = 1'b0;
    logic [31:0] exp_lba;
    logic [15:0] exp_rem;
    logic [1:0]  oh;
    logic [3:0]  exp_oh;
    exp_lba = v.lba;
    oh      = v.exp_tgt ? 2'b10 : 2'b01;
    exp_oh  = v.exp_wr ? {oh, 2'b00} : {2'b00, oh};
    data_rd_req = v.rd;
    data_wr_req = v.wr;
    data_lba    = v.lba;
    data_length = v.len;
    for (cyc = 1; cyc <= 400 && settle < 4; cyc++) begin
      @(negedge clk);
      if (finished) settle++;
      if (data_busy) begin
        c_busy++;
        data_rd_req = '0;
        data_wr_req = '0;
      end
      if (data_done) begin
        c_done++;
        done_cyc = cyc;
        if (!v.early) ack_cnt = v.ack_dly + 1;
      end
      if (data_next) begin
        c_next++;
        if (v.early) chk({nm, " next_latency"}, cyc - done_cyc, 1);
        data_lba = data_lba + 32'd1;
        req_cnt  = v.req_dly + 1;
        if (v.noise) begin
          data_rd_req = v.exp_wr ? 2'b11 : ~oh;
          data_wr_req = v.exp_wr ? ~oh : 2'b11;
        end
      end
      if (dma_done) begin
        c_dma++;
        finished = 1'b1;
        chk({nm, " err_at_end"}, xfer_err, v.exp_err);
        chk({nm, " rem_at_end"}, remaining, 0);
        chk({nm, " busy_with_dma"}, data_busy, (v.len == 16'd0) || v.never_busy);
        if (v.early) chk({nm, " last_latency"}, cyc - done_cyc, 1);
        if (v.never_busy) chk({nm, " timeout_cycles"}, cyc - det_cyc, Tmo);
      end
      if (phase == 0 && (sd_rd != 2'b00 || sd_wr != 2'b00)) begin
        c_sd++;
        det_cyc = cyc;
        exp_rem = v.len - 16'(exp_lba - v.lba);
        chk({nm, " sd_req"}, {sd_wr, sd_rd}, exp_oh);
        chk({nm, " sd_lba"}, sd_lba, exp_lba);
        chk({nm, " remaining"}, remaining, exp_rem);
        chk({nm, " err_clear"}, xfer_err, 0);
        exp_lba  = exp_lba + 32'd1;
        phase    = 1;
        busy_cnt = v.busy_dly;
      end
      sd_busy        = 1'b0;
      sd_done        = 1'b0;
      dma_sector_ack = 1'b0;
      if (early_ack) begin
        dma_sector_ack = 1'b1;
        early_ack      = 1'b0;
      end
      if (phase == 1 && !v.never_busy) begin
        if (busy_cnt == 0) begin
          sd_busy = 1'b1;
          if (v.done_dly == 0) begin
            sd_done = 1'b1;
            phase   = 0;
          end else begin
            done_cnt  = v.done_dly;
            phase     = 2;
            early_ack = v.early;
          end
        end else begin
          busy_cnt--;
        end
      end else if (phase == 2) begin
        done_cnt--;
        if (done_cnt == 0) begin
          sd_done = 1'b1;
          phase   = 0;
        end
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) dma_sector_ack = 1'b1;
      end
      if (req_cnt > 0) begin
        req_cnt--;
        if (req_cnt == 0) begin
          if (v.exp_wr) data_wr_req[v.exp_tgt] = 1'b1;
          else data_rd_req[v.exp_tgt] = 1'b1;
        end
      end
    end
    chk({nm, " completion"}, finished, 1);
    chk({nm, " n_busy"}, c_busy, v.exp_busy);
    chk({nm, " n_done"}, c_done, v.exp_done);
    chk({nm, " n_next"}, c_next, v.exp_next);
    chk({nm, " n_dma"}, c_dma, 1);
    chk({nm, " n_sd"}, c_sd, v.exp_sd);
    data_rd_req = '0;
    data_wr_req = '0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({data_busy, data_done, data_next, dma_done, sd_rd, sd_wr, sd_lba,
                xfer_err, remaining});
  endfunction

  vec_t  vecs[8];
  string names[8];

  initial begin
    vec_t v;
    bit   seen;
    int   n_dma;
    logic [3:0] m;

    //          rd     wr     lba           len       bd do ak rq ea nb no  t  w  b  d  n  s  e
    vecs[0] = '{2'b01, 2'b00, 32'd100,      16'd3,    0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 2, 3, 0};
    vecs[1] = '{2'b00, 2'b10, 32'h2000,     16'd1,    1, 2, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0};
    vecs[2] = '{2'b11, 2'b00, 32'd55,       16'd0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{2'b00, 2'b01, 32'd7,        16'd4,    0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[4] = '{2'b10, 2'b00, 32'd300,      16'd2,    2, 3, 2, 1, 0, 0, 0, 1, 0, 2, 2, 1, 2, 0};
    vecs[5] = '{2'b01, 2'b00, 32'd500,      16'd2,    0, 3, 0, 0, 1, 0, 0, 0, 0, 2, 2, 1, 2, 0};
    vecs[6] = '{2'b10, 2'b01, 32'd40,       16'd2,    1, 1, 1, 3, 0, 0, 1, 0, 1, 2, 2, 1, 2, 0};
    vecs[7] = '{2'b10, 2'b00, 32'hFFFFFFF0, 16'hFFFF, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
    names = '{"rd_t0_len3", "wr_t1_len1", "len0_both", "timeout", "err_clear",
              "early_ack", "prio_noise", "len_ffff"};

    reset = 1'b1;
    data_rd_req = '0;
    data_wr_req = '0;
    data_lba = '0;
    data_length = '0;
    sd_busy = 1'b0;
    sd_done = 1'b0;
    dma_sector_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", all_outs(), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_xfer(vecs[i], names[i]);

    // Reset while waiting for sd_done.
    data_rd_req = 2'b01;
    data_lba    = 32'd900;
    data_length = 16'd2;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      sd_busy = 1'b0;
      if (data_busy) begin
        seen = 1'b1;
        data_rd_req = '0;
      end else if (sd_rd != 2'b00) begin
        sd_busy = 1'b1;
      end
    end
    chk("rst_reach_wait_done", seen, 1);
    chk("rst_pre_remaining", remaining, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outputs_zero", all_outs(), 0);
    reset = 1'b0;
    n_dma = 0;
    repeat (20) begin
      @(negedge clk);
      if (dma_done) n_dma++;
    end
    chk("rst_no_dma_done", n_dma, 0);
    run_xfer(vecs[0], "after_reset");

    for (int k = 0; k < 30; k++) begin
      m = 4'($urandom_range(1, 15));
      v.rd = m[1:0];
      v.wr = m[3:2];
      v.lba = $urandom;
      v.len = 16'($urandom_range(0, 5));
      v.busy_dly = $urandom_range(0, 5);
      v.done_dly = $urandom_range(0, 5);
      v.ack_dly = $urandom_range(0, 5);
      v.req_dly = $urandom_range(0, 4);
      v.early = ($urandom_range(0, 3) == 0);
      if (v.early && v.done_dly == 0) v.done_dly = 1;
      v.never_busy = 1'b0;
      v.noise = $urandom_range(0, 1) == 1;
      v = ref_model(v);
      run_xfer(v, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acsi_sector_sequencer.md
Name: acsi_sector_sequencer

Overview:
Sits directly downstream of the ACSI command block. It takes that block's per-target read/write sector requests (lba, length) and turns them into a sequence of single-sector requests to the SD card controller. It paces each sector against the DMA engine and returns the busy/done/next/dma_done handshakes the ACSI block consumes. One transfer is handled at a time, for target 0 or 1 only.

Parameters:
TIMEOUT, 24'd8000000, clk cycles allowed in any SD wait state before the transfer is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock (one clock domain)
reset  in  1  synchronous, active-high reset
data_rd_req  in  2  per-target read request from ACSI; level, held until data_busy
data_wr_req  in  2  per-target write request from ACSI; level, held until data_busy
data_lba  in  32  start lba; ACSI increments it in the same cycle it sees data_next
data_length  in  16  sector count, sampled at transfer start only
data_busy  out  1  one-cycle pulse: request accepted (ACSI drops its req)
data_done  out  1  one-cycle pulse: SD finished the current sector
data_next  out  1  one-cycle pulse: ask ACSI to re-request the next sector
dma_done  out  1  one-cycle pulse: whole transfer finished or aborted
sd_rd  out  2  per-target sector read request to SD controller
sd_wr  out  2  per-target sector write request to SD controller
sd_lba  out  32  lba of the current sector
sd_busy  in  1  SD controller accepted sd_rd/sd_wr
sd_done  in  1  SD controller finished the sector (pulse)
dma_sector_ack  in  1  DMA has moved all 512 bytes of the current sector (pulse)
xfer_err  out  1  sticky timeout flag; cleared when the next transfer starts
remaining  out  16  sectors still to be transferred, including the current one

Behaviour:
- Reset values: all outputs 0; state IDLE; internal timeout counter 0.
- State IDLE:
  - A request is any bit of data_rd_req or data_wr_req.
  - Selection order: target 0 before target 1; read before write for the same target.
  - On a request: latch the target and direction, remaining<=data_length, sd_lba<=data_lba, clear xfer_err.
  - If data_length==0: pulse data_busy and dma_done in the same cycle and stay in IDLE.
  - Otherwise: assert sd_rd[t] or sd_wr[t] and go to WAIT_BUSY.
- WAIT_BUSY:
  - On sd_busy: drop sd_rd/sd_wr, pulse data_busy, go to WAIT_DONE.
  - sd_busy and sd_done in the same cycle: skip WAIT_DONE and pulse data_busy and data_done together.
- WAIT_DONE: on sd_done, pulse data_done and go to WAIT_DMA.
- WAIT_DMA: on dma_sector_ack, check remaining:
  - remaining==1: remaining<=0, pulse dma_done, go to IDLE.
  - Otherwise: remaining<=remaining-1, pulse data_next, go to WAIT_REQ.
  - A dma_sector_ack that arrives during WAIT_DONE is captured and applied on entry to WAIT_DMA. At most one is held; extra acks are ignored.
- WAIT_REQ:
  - Wait for the ACSI request bit for the same target and direction; requests for any other target/direction are ignored here.
  - On that request: sd_lba<=data_lba (already incremented by ACSI), assert the SD request, go to WAIT_BUSY.
- Timeout:
  - The counter counts up in WAIT_BUSY, WAIT_DONE and WAIT_DMA, and clears on every state change.
  - When it reaches TIMEOUT: drop the SD requests, set xfer_err, remaining<=0, go to IDLE.
  - Same cycle: pulse dma_done; also pulse data_busy if the timeout hit in WAIT_BUSY.
- Every pulse output is high for exactly one clk cycle. No internal path combinationally connects inputs to outputs; every output is registered.
- remaining is 16-bit with no wrap: it is never decremented below 0. data_length=16'hFFFF is legal.
- Reset during a transfer: SD requests drop on the next edge and no dma_done is generated.

Test Plan:
- Read t0, lba=100, length=3, SD/DMA respond promptly -> sd_lba 100, 101, 102 in turn; 3 data_busy, 3 data_done, 2 data_next, one dma_done; remaining ends at 0.
- Write t1, length=1 -> only sd_wr[1] is asserted; dma_done pulses on dma_sector_ack; data_next never pulses.
- data_rd_req=2'b11 with length 0 -> target 0 is chosen; data_busy and dma_done pulse in the same cycle; sd_rd stays 0.
- TIMEOUT=16 and sd_busy never asserts -> after 16 cycles: data_busy and dma_done pulse together, xfer_err=1, state returns to IDLE; xfer_err clears on the next request.
- dma_sector_ack arrives before sd_done, length=2 -> no ack is lost; data_next pulses one cycle after sd_done's state; the transfer completes normally.
- Reset asserted in WAIT_DONE -> all outputs are 0 on the next cycle, no dma_done; a new request afterwards works normally.
